// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALUCtl codes,
// opcode width and the sequencer state encoding.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd8;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd9;
    localparam logic [OP_W-1:0] ALU_BNE  = 4'd10;
    localparam logic [OP_W-1:0] ALU_BLT  = 4'd11;
    localparam logic [OP_W-1:0] ALU_BGE  = 4'd12;
    localparam logic [OP_W-1:0] ALU_BLTU = 4'd13;
    localparam logic [OP_W-1:0] ALU_BGEU = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker: returns a one-hot grant, its index and
// an any-valid flag. Default is round-robin starting at ptr; with
// ALU_ARB_FIXED_PRIO_EN defined the lowest asserted index wins and ptr
// is ignored.
module rr_pick
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    // Scan requesters in priority order and take the first valid one
    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = (32'(ptr) + k) % NREQ;
`endif
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one single-cycle ALU among NREQ requesters. One operation is in
// flight at a time: IDLE arbitrates and latches the request, EXEC presents
// the registered operands to the ALU and captures its outputs, RESP holds
// the response until the owning requester accepts it.
// Optional macro: ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OP_W*NREQ-1:0]  req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      alu_src_a,
    output logic [WIDTH-1:0]      alu_src_b,
    output logic [OP_W-1:0]       alu_ctl,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero
);

    arb_state_t       state, state_n;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             zero_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             req_fire, rsp_fire;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Next-state and handshake decode; req_ready is suppressed during reset
    // so no request is accepted on a reset edge
    always_comb begin
        state_n   = state;
        req_ready = '0;
        rsp_valid = '0;
        req_fire  = 1'b0;
        rsp_fire  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!rst && pick_any) begin
                    req_ready = pick_grant;
                    req_fire  = 1'b1;
                    state_n   = ST_EXEC;
                end
            end
            ST_EXEC: state_n = ST_RESP;
            ST_RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (rsp_ready[id_q]) begin
                    rsp_fire = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Operand latch on request handshake, ALU capture at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= ALU_ADD;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            if (req_fire) begin
                op_q <= req_op[OP_W*pick_idx +: OP_W];
                a_q  <= req_a[WIDTH*pick_idx +: WIDTH];
                b_q  <= req_b[WIDTH*pick_idx +: WIDTH];
                id_q <= pick_idx;
            end
            if (state == ST_EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
        end
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    // Round-robin pointer moves just past the requester that was served
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (rsp_fire) begin
            if (id_q == IDW'(NREQ - 1)) rr_ptr <= '0;
            else                        rr_ptr <= id_q + IDW'(1);
        end
    end
`endif

    assign alu_src_a  = a_q;
    assign alu_src_b  = b_q;
    assign alu_ctl    = op_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_id     = id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomised self-checking bench for alu_share_arb. A behavioural ALU
// answers the DUT's ALU port; a transaction-level model tracks pending
// requests per requester, arbitration order and response timing.
module tb_alu_share_arb;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned IDW   = $clog2(NREQ);

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } txn_t;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] res;
        logic             zero;
        int               gcyc;
        int               ccyc;
    } rsp_log_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [4*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a, req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_zero;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      alu_src_a, alu_src_b, alu_result;
    logic [3:0]            alu_ctl;
    logic                  alu_zero;

    alu_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_id(rsp_id),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; branch ops return !taken as result so Zero=1 means taken
    function automatic logic [WIDTH:0] alu_f(logic [3:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a << b[4:0];
            4'd3:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd4:  r = (a < b) ? 1 : 0;
            4'd5:  r = a ^ b;
            4'd6:  r = a >> b[4:0];
            4'd7:  r = $signed(a) >>> b[4:0];
            4'd8:  r = a | b;
            4'd9:  r = a & b;
            4'd10: r = (a != b) ? 0 : 1;
            4'd11: r = ($signed(a) <  $signed(b)) ? 0 : 1;
            4'd12: r = ($signed(a) >= $signed(b)) ? 0 : 1;
            4'd13: r = (a <  b) ? 0 : 1;
            4'd14: r = (a >= b) ? 0 : 1;
            default: r = '0;
        endcase
        return {(r == '0), r};
    endfunction

    always_comb {alu_zero, alu_result} = alu_f(alu_ctl, alu_src_a, alu_src_b);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    txn_t           q [NREQ][$];
    rsp_log_t       log_q [$];
    int             hold [NREQ];
    int             rdy_pct = 100;
    int             cyc = 0;
    bit             m_busy = 0;
    int             m_phase = 0;
    int             m_id = 0;
    int             m_ptr = 0;
    int             m_gcyc = 0;
    txn_t           m_txn;
    logic [WIDTH:0] m_exp;

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += q[i].size();
        return s;
    endfunction

    task automatic push_op(input int r, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        txn_t t;
        t.op = op; t.a = a; t.b = b;
        q[r].push_back(t);
    endtask

    // Head of each queue is presented; idle requesters get junk operands
    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_op[4*i +: 4]       = q[i][0].op;
                req_a[WIDTH*i +: WIDTH] = q[i][0].a;
                req_b[WIDTH*i +: WIDTH] = q[i][0].b;
            end else begin
                req_valid[i]           = 1'b0;
                req_op[4*i +: 4]       = 4'($urandom);
                req_a[WIDTH*i +: WIDTH] = $urandom;
                req_b[WIDTH*i +: WIDTH] = $urandom;
            end
        end
    endtask

    task automatic drive_rsp_ready();
        for (int i = 0; i < NREQ; i++)
            rsp_ready[i] = ($urandom_range(99) < rdy_pct);
    endtask

    // One clock of stimulus and checking; entered and left at posedge+1
    task automatic step();
        int w;
        logic [NREQ-1:0] exp_rdy, exp_vld;
        drive_reqs();
        @(negedge clk);
        if (!m_busy) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
`ifdef ALU_ARB_FIXED_PRIO_EN
                j = k;
`else
                j = (m_ptr + k) % NREQ;
`endif
                if (w < 0 && q[j].size() > 0) w = j;
            end
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            check_eq("idle_req_ready", req_ready, exp_rdy);
            check_eq("idle_rsp_valid", rsp_valid, 0);
            drive_rsp_ready();
            if (w >= 0) begin
                m_busy  = 1;
                m_phase = 1;
                m_id    = w;
                m_txn   = q[w].pop_front();
                m_exp   = alu_f(m_txn.op, m_txn.a, m_txn.b);
                m_gcyc  = cyc;
            end
        end else if (m_phase == 1) begin
            check_eq("exec_alu_ctl", alu_ctl, m_txn.op);
            check_eq("exec_alu_a", alu_src_a, m_txn.a);
            check_eq("exec_alu_b", alu_src_b, m_txn.b);
            check_eq("exec_req_ready", req_ready, 0);
            check_eq("exec_rsp_valid", rsp_valid, 0);
            drive_rsp_ready();
            m_phase = 2;
        end else begin
            exp_vld = '0;
            exp_vld[m_id] = 1'b1;
            check_eq("resp_rsp_valid", rsp_valid, exp_vld);
            check_eq("resp_result", rsp_result, m_exp[WIDTH-1:0]);
            check_eq("resp_zero", rsp_zero, m_exp[WIDTH]);
            check_eq("resp_id", rsp_id, m_id);
            check_eq("resp_req_ready", req_ready, 0);
            drive_rsp_ready();
            if (hold[m_id] > 0) begin
                rsp_ready[m_id] = 1'b0;
                hold[m_id]--;
            end
            if (rsp_ready[m_id]) begin
                rsp_log_t e;
                e.id = m_id; e.res = rsp_result; e.zero = rsp_zero;
                e.gcyc = m_gcyc; e.ccyc = cyc;
                log_q.push_back(e);
                m_busy = 0;
                m_ptr  = (m_id + 1) % NREQ;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((m_busy || pending() > 0) && n < limit) begin
            step();
            n++;
        end
        check_eq("drain_complete", {63'b0, (m_busy || pending() > 0)}, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_result"}, rsp_result, 0);
        check_eq({tag, "_rsp_zero"}, rsp_zero, 0);
        check_eq({tag, "_rsp_id"}, rsp_id, 0);
        check_eq({tag, "_alu_a"}, alu_src_a, 0);
        check_eq({tag, "_alu_b"}, alu_src_b, 0);
        check_eq({tag, "_alu_ctl"}, alu_ctl, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_reqs();
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 0;
        m_ptr  = 0;
    endtask

    initial begin
        int n;
        int pushed;
        int exp_ids [4];
        int first1;
        rst = 1'b1;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) hold[i] = 0;
        do_reset();

        // Single ADD from requester 0
        log_q.delete();
        push_op(0, 4'd0, 32'd5, 32'd7);
        drain(50);
        check_eq("single_count", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            check_eq("single_result", log_q[0].res, 12);
            check_eq("single_zero", log_q[0].zero, 0);
            check_eq("single_id", log_q[0].id, 0);
            check_eq("single_latency", log_q[0].ccyc - log_q[0].gcyc, 2);
        end

        // Contention: both valid through reset
        log_q.delete();
        push_op(0, 4'd1, 32'd9, 32'd9);
        push_op(0, 4'd0, 32'd1, 32'd2);
        push_op(1, 4'd3, 32'hFFFF_FFFF, 32'd1);
        push_op(1, 4'd5, 32'h0000_00F0, 32'h0000_000F);
        do_reset();
        drain(100);
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 1, 1};
        first1 = 2;
`else
        exp_ids = '{0, 1, 0, 1};
        first1 = 1;
`endif
        check_eq("cont_count", log_q.size(), 4);
        if (log_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) check_eq("cont_order", log_q[k].id, exp_ids[k]);
            check_eq("cont_sub_result", log_q[0].res, 0);
            check_eq("cont_sub_zero", log_q[0].zero, 1);
            check_eq("cont_slt_result", log_q[first1].res, 1);
            check_eq("cont_slt_zero", log_q[first1].zero, 0);
        end

        // Backpressure on requester 1 while requester 0 waits
        log_q.delete();
        push_op(1, 4'd12, 32'hFFFF_FFFF, 32'd0);
        hold[1] = 5;
        n = 0;
        while (!m_busy && n < 20) begin step(); n++; end
        push_op(0, 4'd0, 32'd100, 32'd23);
        drain(100);
        check_eq("bp_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check_eq("bp_id", log_q[0].id, 1);
            check_eq("bge_result", log_q[0].res, 1);
            check_eq("bge_zero", log_q[0].zero, 0);
            check_eq("bp_stall_len", log_q[0].ccyc - log_q[0].gcyc, 7);
            check_eq("bp_next_id", log_q[1].id, 0);
            check_eq("bp_next_grant", log_q[1].gcyc, log_q[0].ccyc + 1);
            check_eq("bp_next_result", log_q[1].res, 123);
        end

        // BLTU and opcode 15
        log_q.delete();
        push_op(1, 4'd13, 32'hFFFF_FFFF, 32'd0);
        drain(50);
        push_op(0, 4'd15, 32'h0000_FFFF, 32'h0000_FFFF);
        drain(50);
        check_eq("br_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check_eq("bltu_result", log_q[0].res, 1);
            check_eq("bltu_zero", log_q[0].zero, 0);
            check_eq("op15_result", log_q[1].res, 0);
            check_eq("op15_zero", log_q[1].zero, 1);
        end

        // Reset while a response is pending
        log_q.delete();
        push_op(0, 4'd0, 32'd3, 32'd4);
        hold[0] = 1000;
        n = 0;
        while (!(m_busy && m_phase == 2) && n < 20) begin step(); n++; end
        step();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        m_busy = 0; m_ptr = 0; hold[0] = 0;
        @(posedge clk);
        #1;
        repeat (4) step();
        check_eq("midrst_no_rsp", log_q.size(), 0);
        push_op(1, 4'd1, 32'd50, 32'd8);
        drain(50);
        check_eq("midrst_count", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            check_eq("midrst_id", log_q[0].id, 1);
            check_eq("midrst_result", log_q[0].res, 42);
        end

        // Randomised traffic with response backpressure
        log_q.delete();
        rdy_pct = 60;
        pushed = 0;
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(2) == 0) begin
                logic [WIDTH-1:0] a;
                a = $urandom;
                push_op(int'($urandom_range(NREQ - 1)), 4'($urandom_range(15)), a,
                        ($urandom_range(3) == 0) ? a : $urandom);
                pushed++;
            end
            step();
        end
        drain(5000);
        check_eq("rand_count", log_q.size(), pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares the single-cycle datapath ALU among `NREQ` requesters, such as the execute stage and a branch-compare or address-generation client. It accepts one operation at a time over a valid/ready handshake and drives the registered operands and opcode onto the ALU ports. It captures `ALUResult`/`Zero` one cycle later and returns them to the granted requester over a valid/ready response channel.

## Interface
- `WIDTH`, 32, operand/result width
- `NREQ`, 2, number of requesters (2..4)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero
- `req_op`  in  4*NREQ  ALUCtl code, requester i at [4i+3:4i]
- `req_a`, `req_b`  in  WIDTH*NREQ  operands, requester i at [WIDTH*i+WIDTH-1:WIDTH*i]
- `rsp_valid`  out  NREQ  response valid, one-hot or zero
- `rsp_ready`  in  NREQ  per-requester response accept
- `rsp_result`  out  WIDTH  captured ALUResult (shared bus)
- `rsp_zero`  out  1  captured Zero (branch ops: 1 = taken)
- `rsp_id`  out  $clog2(NREQ)  index of responding requester
- `alu_src_a`, `alu_src_b`  out  WIDTH  to ALU SrcA/SrcB
- `alu_ctl`  out  4  to ALU ALUCtl
- `alu_result`  in  WIDTH  from ALU
- `alu_zero`  in  1  from ALU

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE:**
  - Winner = first asserted `req_valid` searching upward from `rr_ptr`, wrapping modulo NREQ.
  - `req_ready[winner]` = 1 combinationally, only in IDLE.
  - On handshake: latch op, A, B and winner id into `op_q/a_q/b_q/id_q`, then go to EXEC.
  - No valid request: stay in IDLE.
- **EXEC:**
  - `alu_*` outputs are driven from the latched registers; these registers drive the outputs in every state.
  - At the end of the cycle, `alu_result`/`alu_zero` are captured into `rsp_result`/`rsp_zero`; go to RESP.
- **RESP:**
  - `rsp_valid[id_q]` = 1; result, zero and id are held stable until `rsp_ready[id_q]`.
  - On handshake: `rr_ptr` ← (id_q+1) mod NREQ; go to IDLE.
  - `rsp_ready` of other requesters is ignored.
- **Opcodes:**
  - Passed through unchanged; the block does not decode them.
  - Code 15 is forwarded; the ALU default yields result 0, zero 1.
- **Request stability:** `req_*` inputs of non-granted requesters may change freely; only the handshake cycle is sampled.
- **Simultaneous requests:** exactly one grant per IDLE cycle. A losing requester keeps valid asserted and wins the next arbitration, since the pointer moves past the winner.
- **Reset mid-operation:**
  - The in-flight op is discarded; no response is issued.
  - `rr_ptr` = 0.
  - All outputs return to reset values on the next edge.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_result` = 0, `rsp_zero` = 0, `rsp_id` = 0.
  - `alu_src_a` = 0, `alu_src_b` = 0, `alu_ctl` = 0 (ADD).
  - `rr_ptr` = 0; state = IDLE.
- Request handshake in cycle T: ALU operands valid in T+1; `rsp_valid` high from T+2.
- Minimum occupancy per op: 3 cycles (IDLE, EXEC, RESP with immediate `rsp_ready`); peak throughput 1 op per 3 cycles.
- Response backpressure stalls indefinitely in RESP; `req_ready` stays 0 throughout.
- No combinational path from `rsp_ready` to `req_ready`, and none from `alu_result` to any output.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Defined: arbitration is fixed priority, lowest index wins; `rr_ptr` is not implemented.
  - Undefined (default): round-robin as specified above.

## Structure
- Shared package `alu_pkg`:
  - ALUCtl localparams: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, BNE=10, BLT=11, BGE=12, BLTU=13, BGEU=14.
  - Opcode width constant 4.
  - FSM state encoding.
- Sub-module `rr_pick`: combinational round-robin picker taking (valid vector, pointer) and returning (one-hot grant, index, any). Its fixed-priority variant is selected by the macro. The FSM stays in the top module.

## Test plan
- Reset, then single op: req0 sends op=ADD, A=5, B=7. Expect `alu_ctl`=0 at T+1 and `rsp_valid[0]`=1 at T+2 with `rsp_result`=12, `rsp_zero`=0, `rsp_id`=0.
- Contention: both requesters hold valid from reset; req0 sends SUB 9-9, req1 sends SLT −1<1. Expect req0 granted first with result 0, zero 1; then req1 with result 1, zero 0. Continuing contention alternates grants (0, 1, 0, 1), or gives all grants to 0 with `ALU_ARB_FIXED_PRIO_EN`.
- Backpressure: `rsp_ready[1]`=0 for 5 cycles after `rsp_valid[1]` rises. Result/id must stay constant, all `req_ready` stay 0, and req0 is granted the cycle after the release.
- Branch op: req1 sends BGE A=0xFFFFFFFF, B=0. Expect `rsp_result`=1, `rsp_zero`=0 (not taken). Then BLTU with the same operands: `rsp_result`=1, `rsp_zero`=0.
- Reset in RESP with `rsp_valid[0]`=1: `rst` pulsed for one cycle. Next cycle all outputs are 0 and no response appears afterward; a subsequent request from req1 is served normally.
- Opcode 15 with A=B=0xFFFF: expect `rsp_result`=0, `rsp_zero`=1.
